// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, data-size codes, FSM encoding and EX->MEM bus layout
package mem_stage_pkg;

    localparam int EXMEM_W  = 107;
    localparam int PCINST_W = 64;
    localparam int TO_WB_W  = 38;   // {regs_we, regs_waddr[4:0], regs_wdata[31:0]}
    localparam int TO_ID_W  = 39;   // {fwd_we, fwd_waddr[4:0], fwd_wdata[31:0], fwd_pending}

    // mem_data_src codes; stores only use SRC_WORD and SRC_BYTE_S
    localparam logic [1:0] SRC_WORD   = 2'd0;
    localparam logic [1:0] SRC_BYTE_S = 2'd1;
    localparam logic [1:0] SRC_BYTE_U = 2'd2;
    localparam logic [1:0] SRC_HALF_S = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Field order matches the EX stage packing, MSB first
    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        regs_wdata_src;  // 0 = EX result, 1 = load data
        logic [1:0]  mem_data_src;
        logic [31:0] mem_rwaddr;
        logic [31:0] mem_wdata;
        logic        regs_we;
        logic [4:0]  regs_waddr;
        logic [31:0] regs_wdata;
    } exmem_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension
// Ports:
//   rdata_i     raw 32-bit bus read data
//   addr_lo_i   byte offset of the access (addr[1:0])
//   data_src_i  access size/extension code
//   result_o    extended 32-bit register value
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  data_src_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[8*addr_lo_i +: 8];
    assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        result_o = rdata_i;
        case (data_src_i)
            SRC_BYTE_S: result_o = {{24{byte_lane[7]}}, byte_lane};
            SRC_BYTE_U: result_o = {24'd0, byte_lane};
            SRC_HALF_S: result_o = {{16{half_lane[15]}}, half_lane};
            default:    result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with split-handshake data bus
// Optional feature: define MEM_FWD_EN to drive the ID forwarding bus (otherwise tied to 0).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid_i / mem_allowin_o  EX->MEM handshake; exmem_to_ibus, pc_inst_ibus carried with it
//   mem_to_wb_valid_o / wb_allowin_i  MEM->WB handshake; to_wb_obus, pc_inst_obus carried with it
//   to_id_obus                  {fwd_we, fwd_waddr, fwd_wdata, fwd_pending}
//   data_req_o .. data_wdata_o  request side of the data bus
//   data_addr_ok_i, data_data_ok_i, data_rdata_i  bus acceptance and response
module mem_stage #(
    parameter int EXMEM_W  = mem_stage_pkg::EXMEM_W,
    parameter int PCINST_W = mem_stage_pkg::PCINST_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ex_valid_i,
    output logic                             mem_allowin_o,
    input  logic [EXMEM_W-1:0]               exmem_to_ibus,
    input  logic [PCINST_W-1:0]              pc_inst_ibus,
    input  logic                             wb_allowin_i,
    output logic                             mem_to_wb_valid_o,
    output logic [mem_stage_pkg::TO_WB_W-1:0] to_wb_obus,
    output logic [PCINST_W-1:0]              pc_inst_obus,
    output logic [mem_stage_pkg::TO_ID_W-1:0] to_id_obus,
    output logic                             data_req_o,
    output logic                             data_wr_o,
    output logic [3:0]                       data_wstrb_o,
    output logic [31:0]                      data_addr_o,
    output logic [31:0]                      data_wdata_o,
    input  logic                             data_addr_ok_i,
    input  logic                             data_data_ok_i,
    input  logic [31:0]                      data_rdata_i
);
    import mem_stage_pkg::*;

    exmem_bus_t          ex_bus;
    exmem_bus_t          exmem_q, exmem_d;
    logic                mem_valid_q, mem_valid_d;
    logic [PCINST_W-1:0] pc_inst_q, pc_inst_d;
    mem_state_e          state_q, state_d;
    logic [31:0]         rbuf_q, rbuf_d;

    logic        is_mem, is_store, is_load;
    logic        ready_go, latch, leave, new_mem, data_ok_now;
    logic [31:0] load_src, load_data, wb_wdata;
    logic        wb_we;

    assign ex_bus = exmem_bus_t'(exmem_to_ibus);

    assign is_mem   = exmem_q.mem_req;
    assign is_store = exmem_q.mem_req & exmem_q.mem_we;
    assign is_load  = exmem_q.mem_req & exmem_q.regs_wdata_src;

    assign data_ok_now = (state_q == ST_WAIT) & data_data_ok_i;
    assign ready_go    = !is_mem | data_ok_now | (state_q == ST_DONE);

    assign mem_allowin_o     = !mem_valid_q | (ready_go & wb_allowin_i);
    assign mem_to_wb_valid_o = mem_valid_q & ready_go;
    assign latch             = ex_valid_i & mem_allowin_o;
    assign new_mem           = latch & ex_bus.mem_req;
    assign leave             = mem_valid_q & ready_go & wb_allowin_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            exmem_q     <= '0;
            pc_inst_q   <= '0;
            state_q     <= ST_IDLE;
            rbuf_q      <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            exmem_q     <= exmem_d;
            pc_inst_q   <= pc_inst_d;
            state_q     <= state_d;
            rbuf_q      <= rbuf_d;
        end
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        exmem_d     = exmem_q;
        pc_inst_d   = pc_inst_q;
        if (mem_allowin_o) begin
            mem_valid_d = ex_valid_i;
        end
        if (latch) begin
            exmem_d   = ex_bus;
            pc_inst_d = pc_inst_ibus;
        end
    end

    // Raw bus data is buffered; alignment is applied on the way out so
    // the same aligner serves both the data_ok cycle and DONE.
    assign rbuf_d = data_ok_now ? data_rdata_i : rbuf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (new_mem) state_d = ST_REQ;
            ST_REQ:  if (data_addr_ok_i) state_d = ST_WAIT;
            ST_WAIT: begin
                if (data_data_ok_i) begin
                    if (new_mem)    state_d = ST_REQ;
                    else if (leave) state_d = ST_IDLE;
                    else            state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (new_mem)           state_d = ST_REQ;
                else if (wb_allowin_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_req_o = (state_q == ST_REQ);
    assign data_wr_o  = is_store;

    always_comb begin
        data_addr_o = exmem_q.mem_rwaddr;
        case (exmem_q.mem_data_src)
            SRC_WORD:   data_addr_o[1:0] = 2'b00;
            SRC_HALF_S: data_addr_o[0]   = 1'b0;
            default:    ;
        endcase
    end

    always_comb begin
        data_wstrb_o = 4'b0000;
        if (is_store) begin
            data_wstrb_o = (exmem_q.mem_data_src == SRC_WORD) ? 4'b1111
                         : (4'b0001 << exmem_q.mem_rwaddr[1:0]);
        end
    end

    assign data_wdata_o = (exmem_q.mem_data_src == SRC_WORD) ? exmem_q.mem_wdata
                        : {4{exmem_q.mem_wdata[7:0]}};

    assign load_src = (state_q == ST_DONE) ? rbuf_q : data_rdata_i;

    mem_load_align u_load_align (
        .rdata_i    (load_src),
        .addr_lo_i  (exmem_q.mem_rwaddr[1:0]),
        .data_src_i (exmem_q.mem_data_src),
        .result_o   (load_data)
    );

    assign wb_we      = exmem_q.regs_we & !is_store;
    assign wb_wdata   = exmem_q.regs_wdata_src ? load_data : exmem_q.regs_wdata;
    assign to_wb_obus = {wb_we, exmem_q.regs_waddr, wb_wdata};
    assign pc_inst_obus = pc_inst_q;

`ifdef MEM_FWD_EN
    // Pending tells ID the register value is not yet known, so it must stall on a match
    assign to_id_obus = {mem_valid_q & wb_we, exmem_q.regs_waddr, wb_wdata,
                         mem_valid_q & is_load & !ready_go};
`else
    assign to_id_obus = '0;
`endif

endmodule
